// File: rtl/uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// uart_tx_arbiter
//   Shares one serial transmitter among NUM_REQ byte-stream requesters.
//   Requesters are picked round-robin, and the winner keeps the transmitter
//   until it sends a byte flagged last. If the owner stalls mid-frame for
//   MAX_HOLD cycles, its lock is released.
//
// Ports
//   clk        in   system clock
//   rst_n      in   asynchronous active-low reset
//   req_valid  in   [NUM_REQ]             per-requester byte valid
//   req_data   in   [NUM_REQ*DATA_WIDTH]  packed bytes, requester i at i*DATA_WIDTH
//   req_last   in   [NUM_REQ]             final byte of the frame (qualified by valid)
//   req_ready  out  [NUM_REQ]             accept strobe, one-hot or zero
//   tx_din     out  [DATA_WIDTH]          registered byte to the transmitter
//   tx_start   out                        registered one-cycle start pulse
//   tx_done    in                         one-cycle completion pulse from the transmitter
//   grant_id   out  [ID_W]                current or most recent owner
//   busy       out                        high whenever not arbitrating
// -----------------------------------------------------------------------------
module uart_tx_arbiter #(
    parameter  int NUM_REQ    = 4,
    parameter  int DATA_WIDTH = 8,
    parameter  int MAX_HOLD   = 1024,
    localparam int ID_W       = $clog2(NUM_REQ)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    input  logic [NUM_REQ-1:0]            req_last,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic [DATA_WIDTH-1:0]         tx_din,
    output logic                          tx_start,
    input  logic                          tx_done,
    output logic [ID_W-1:0]               grant_id,
    output logic                          busy
);

    localparam int HCW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    localparam logic [HCW-1:0] HOLD_LAST = HCW'(MAX_HOLD - 1);

    typedef enum logic [1:0] {
        ST_ARB   = 2'd0,
        ST_START = 2'd1,
        ST_WAIT  = 2'd2,
        ST_HOLD  = 2'd3
    } state_t;

    state_t                  state_q, state_d;
    logic [DATA_WIDTH-1:0]   tx_din_q, tx_din_d;
    logic                    tx_start_q, tx_start_d;
    logic [ID_W-1:0]         grant_id_q, grant_id_d;
    logic [ID_W-1:0]         ptr_q, ptr_d;
    logic [HCW-1:0]          hold_cnt_q, hold_cnt_d;
    logic                    locked_q, locked_d;

    logic                    win_found;
    logic [ID_W-1:0]         win_id;
    logic [NUM_REQ-1:0]      ready_c;

    // Round-robin search starting one past the last winner. The modulo keeps
    // the rotation correct for non-power-of-2 requester counts.
    always_comb begin
        win_found = 1'b0;
        win_id    = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            if (!win_found && req_valid[(int'(ptr_q) + k) % NUM_REQ]) begin
                win_found = 1'b1;
                win_id    = ID_W'((int'(ptr_q) + k) % NUM_REQ);
            end
        end
    end

    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves
        // one unassigned; that is what keeps this block from inferring latches.
        state_d    = state_q;
        tx_din_d   = tx_din_q;
        grant_id_d = grant_id_q;
        ptr_d      = ptr_q;
        hold_cnt_d = hold_cnt_q;
        locked_d   = locked_q;
        ready_c    = '0;

        case (state_q)
            ST_ARB: begin
                if (win_found) begin
                    ready_c[win_id] = 1'b1;
                    tx_din_d        = req_data[win_id*DATA_WIDTH +: DATA_WIDTH];
                    grant_id_d      = win_id;
                    ptr_d           = win_id;
                    locked_d        = !req_last[win_id];
                    state_d         = ST_START;
                end
            end
            ST_START: state_d = ST_WAIT;
            ST_WAIT: begin
                if (tx_done) begin
                    if (locked_q) begin
                        state_d    = ST_HOLD;
                        hold_cnt_d = '0;
                    end else begin
                        state_d = ST_ARB;
                    end
                end
            end
            ST_HOLD: begin
                // An owner transfer takes precedence over a timeout landing
                // in the same cycle.
                if (req_valid[grant_id_q]) begin
                    ready_c[grant_id_q] = 1'b1;
                    tx_din_d   = req_data[grant_id_q*DATA_WIDTH +: DATA_WIDTH];
                    locked_d   = !req_last[grant_id_q];
                    hold_cnt_d = '0;
                    state_d    = ST_START;
                end else if (hold_cnt_q == HOLD_LAST) begin
                    locked_d   = 1'b0;
                    hold_cnt_d = '0;
                    state_d    = ST_ARB;
                end else begin
                    hold_cnt_d = hold_cnt_q + 1'b1;
                end
            end
            default: state_d = ST_ARB;
        endcase

        tx_start_d = (state_d == ST_START);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_ARB;
            tx_din_q   <= '0;
            tx_start_q <= 1'b0;
            grant_id_q <= '0;
            ptr_q      <= ID_W'(NUM_REQ - 1);
            hold_cnt_q <= '0;
            locked_q   <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // flop samples the pre-edge values computed above.
            state_q    <= state_d;
            tx_din_q   <= tx_din_d;
            tx_start_q <= tx_start_d;
            grant_id_q <= grant_id_d;
            ptr_q      <= ptr_d;
            hold_cnt_q <= hold_cnt_d;
            locked_q   <= locked_d;
        end
    end

    // req_ready is combinational from req_valid, so it is gated by reset to
    // guarantee no handshake completes while rst_n is low.
    assign req_ready = rst_n ? ready_c : '0;
    assign tx_din    = tx_din_q;
    assign tx_start  = tx_start_q;
    assign grant_id  = grant_id_q;
    assign busy      = (state_q != ST_ARB);

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares one serial transmitter among NUM_REQ byte-stream requesters using round-robin arbitration with frame locking.
- Accepts bytes over valid/ready, drives the transmitter's din/tx_start pair, and waits for its tx_done pulse before issuing the next byte.
- Once a requester wins, it keeps the transmitter until it sends a byte flagged last, or until a hold timeout expires.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- DATA_WIDTH, 8, byte width; matches transmitter din.
- MAX_HOLD, 1024, max idle cycles a locked owner may stall mid-frame before the lock is released.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  NUM_REQ  per-requester byte valid
- req_data  in  NUM_REQ*DATA_WIDTH  packed bytes; requester i at bits [i*DATA_WIDTH +: DATA_WIDTH]
- req_last  in  NUM_REQ  byte is the final byte of the frame (sampled with valid)
- req_ready  out  NUM_REQ  per-requester accept; one-hot or zero
- tx_din  out  DATA_WIDTH  byte to transmitter, registered
- tx_start  out  1  one-cycle start pulse to transmitter, registered
- tx_done  in  1  one-cycle completion pulse from transmitter
- grant_id  out  $clog2(NUM_REQ)  current or most recent owner, registered
- busy  out  1  high in any state other than ARB

Behaviour:
- Reset values: state ARB, tx_din 0, tx_start 0, grant_id 0, busy 0, ptr NUM_REQ-1 (so requester 0 has first priority), hold_cnt 0, locked 0.
- States and transitions:
  - ARB: winner = first i with req_valid[i], searching from (ptr+1) mod NUM_REQ and wrapping. If a winner exists:
    - req_ready[winner]=1 combinationally; the transfer occurs this cycle.
    - Latch tx_din=req_data[winner], grant_id=winner, ptr=winner, locked=!req_last[winner].
    - Next state: START.
    - With no valid request, stay in ARB.
  - START: tx_start=1 for exactly this one cycle; next state WAIT.
  - WAIT: hold until tx_done=1. Then go to HOLD if locked, else ARB. tx_done is ignored in all other states.
  - HOLD: only the owner may transfer. req_ready[grant_id]=req_valid[grant_id]. On transfer:
    - Latch data, set locked=!req_last, clear hold_cnt, go to START.
    - Otherwise increment hold_cnt. When hold_cnt==MAX_HOLD-1 with no transfer, clear locked and go to ARB.
- The next arbitration after a release starts from owner+1. A released owner gets no priority boost.
- req_ready is never asserted in START or WAIT. At most one bit is set at any time.
- Latency: byte accepted in cycle T gives tx_start high in T+1. The earliest next accept is the cycle after tx_done.
- Simultaneous events:
  - A non-owner's valid during HOLD is ignored; it waits.
  - A timeout firing in the same cycle as an owner transfer: the transfer wins, and the counter clears.
- Async reset mid-frame: all state returns to reset values immediately. tx_start drops, and no byte is accepted in the reset cycle.
- Width rules: hold_cnt is $clog2(MAX_HOLD) bits and never wraps (bounded by the timeout). ptr arithmetic is modulo NUM_REQ, including non-power-of-2 values.

Test Plan:
- Single requester: req0 sends 0xA5 with last=1 → req_ready[0] pulses once, tx_din=0xA5, tx_start high exactly 1 cycle after accept; returns to ARB after tx_done, busy=0.
- Round-robin: req0..3 all valid with last=1 from reset → grant order 0,1,2,3,0; each grant_id updates at its accept; no double tx_start.
- Frame lock: req1 sends 0x11,0x22,0x33 (last on 0x33) while req2 is continuously valid → req2 accepted only after 0x33's tx_done.
- Hold timeout: MAX_HOLD=16; req0 sends 0x10 with last=0, then deasserts valid → after tx_done, exactly 16 cycles in HOLD, then req3 (valid) granted.
- Spurious/early done: tx_done pulsed in ARB and in START → no state change; tx_start still a single pulse.
- Reset mid-WAIT: assert rst_n=0 while in WAIT → tx_start=0, req_ready=0, busy=0 immediately; after release, req0 wins first.
